pipelined_control_unit: RTL and testbench
=========================================

Name: pipelined_control_unit

Overview:
- Next-generation controller for the 5-stage RV32I core.
- Decodes the ID-stage instruction into a control bundle. Covers the full RV32I ALU set, loads/stores, all six branches, JAL/JALR, LUI and AUIPC.
- Carries the bundle through its own ID/EX, EX/MEM and MEM/WB registers, with stall and flush, and resolves PC redirect in EX from ALU flags.
- Replaces the per-stage control pipeline registers previously kept in the datapath.

Parameters:
- ALU_CTRL_W, 4, width of the ALU control code; must be >= 4.
- RESULT_SRC_W, 2, width of the result-select code.
- IMM_SRC_W, 3, width of the immediate-format select.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- instr_d  in  32  instruction held in the IF/ID register
- stall_e  in  1  hold the ID/EX control register
- flush_e  in  1  replace the ID/EX contents with a bubble
- zero_e  in  1  ALU result == 0
- lt_e  in  1  signed rs1 < rs2
- ltu_e  in  1  unsigned rs1 < rs2
- imm_src_d  out  IMM_SRC_W  immediate format for the D-stage extender: 0 I, 1 S, 2 B, 3 J, 4 U
- illegal_d  out  1  unsupported opcode/funct in D
- alu_ctrl_e  out  ALU_CTRL_W  ALU operation in EX
- alu_src_a_e  out  1  select PC as operand A (AUIPC, JAL)
- alu_src_b_e  out  1  select the immediate as operand B
- pc_src_e  out  1  redirect fetch
- pc_target_sel_e  out  1  target is ALU result (JALR); otherwise PC+imm
- result_src_e  out  RESULT_SRC_W  exported for load-use detection
- reg_write_e  out  1  exported for the hazard unit
- mem_write_m  out  1  data-memory write strobe
- funct3_m  out  3  memory access size/sign
- reg_write_m  out  1  register write in MEM
- result_src_m  out  RESULT_SRC_W  result select in MEM
- reg_write_w  out  1  register file write enable
- result_src_w  out  RESULT_SRC_W  writeback select: 0 ALU, 1 memory, 2 PC+4

Behaviour:
- Decode is combinational from instr_d. imm_src_d and illegal_d have zero latency.
- ALU codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA
  - 10 PASS_B (LUI)
- SUB is selected only for R-type with funct7[5]=1. I-type ADDI never selects SUB. SRAI is selected by funct7[5].
- Loads, stores, JALR and AUIPC use ADD. Branches use SUB.
- Illegal instruction:
  - Any unknown opcode, or a reserved funct3/funct7 combination, sets illegal_d=1.
  - It decodes to a bubble: all write/branch/jump enables 0.
- ID/EX register, per clock, in priority order:
  - flush_e=1 loads a bubble, even if stall_e=1.
  - Otherwise stall_e=1 holds the current contents.
  - Otherwise it captures the D decode.
- EX/MEM and MEM/WB registers advance unconditionally every cycle.
- Latency: an instruction's E outputs appear 1 cycle after it is in D. M outputs follow 1 cycle later, W outputs 1 cycle after M.
- Branch resolution (combinational in EX): pc_src_e = jump_e | (branch_e & cond).
  - cond by funct3_e: BEQ zero, BNE !zero, BLT lt, BGE !lt, BLTU ltu, BGEU !ltu.
  - A bubble has branch_e=jump_e=0, so pc_src_e=0.
- Reset (asynchronous, rst_n=0): all pipeline registers clear to the bubble state (all stored fields 0). Every registered output and pc_src_e therefore reads 0.
- Reset asserted mid-pipeline discards all in-flight control; the first valid E output appears 1 cycle after release.
- Bubble definition: reg_write=0, mem_write=0, branch=0, jump=0; other fields 0.

Optional Feature:
- Macro: CTRL_MEXT_EN.
- Defined:
  - OP with funct7=0000001 decodes the M extension.
  - ALU codes: 11 MUL, 12 MULH, 13 MULHSU, 14 MULHU. funct3 4–7 (DIV/DIVU/REM/REMU) remain illegal.
- Undefined: every funct7=0000001 OP instruction sets illegal_d and decodes as a bubble.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode constants
  - ALU code constants
  - imm-format and result-select constants
  - the control-bundle struct and its BUBBLE constant
- One sub-module, ctrl_decoder: the purely combinational instr to bundle/imm_src/illegal decode.
- The top holds the three registers and the branch-resolution logic.

Test Plan:
- Reset: rst_n low with instr_d=ADD → all E/M/W outputs 0; after release, alu_ctrl_e=0 and reg_write_e=1 next cycle.
- SUB x3,x1,x2 (0x402081B3) → alu_ctrl_e=1. ADDI 0x00500093 → alu_ctrl_e=0, alu_src_b_e=1. SRAI with funct7[5]=1 → alu_ctrl_e=9.
- BLT with lt_e=1 → pc_src_e=1; same BLT with lt_e=0 → pc_src_e=0. BGEU with ltu_e=0 → pc_src_e=1.
- LW followed by three ADDs → result_src_e=1, then result_src_m=1, then result_src_w=1 on successive cycles; funct3_m=2.
- JAL in E with flush_e and stall_e both asserted → next cycle E is a bubble and pc_src_e=0. stall_e alone → E fields held for 2 cycles.
- MUL (0x02208033) → with CTRL_MEXT_EN, alu_ctrl_e=11 and illegal_d=0; without it, illegal_d=1 and reg_write_e=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the RV32I pipelined control unit: opcodes, ALU codes,
// immediate/result selects and the control bundle carried down the pipeline.
package ctrl_pkg;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OP_IMM = 7'b0010011,
        OPC_AUIPC  = 7'b0010111,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111
    } opcode_t;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_AND    = 4'd2,
        ALU_OR     = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_SLT    = 4'd5,
        ALU_SLTU   = 4'd6,
        ALU_SLL    = 4'd7,
        ALU_SRL    = 4'd8,
        ALU_SRA    = 4'd9,
        ALU_PASS_B = 4'd10,
        ALU_MUL    = 4'd11,
        ALU_MULH   = 4'd12,
        ALU_MULHSU = 4'd13,
        ALU_MULHU  = 4'd14
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_J = 3'd3,
        IMM_U = 3'd4
    } imm_fmt_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'd0,
        RES_MEM = 2'd1,
        RES_PC4 = 2'd2
    } result_sel_t;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        alu_src_a;
        logic        alu_src_b;
        logic        pc_target_sel;
        result_sel_t result_src;
        alu_op_t     alu_ctrl;
        logic [2:0]  funct3;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

    // Shared funct3 map for OP and OP-IMM; alt picks SRA over SRL.
    function automatic alu_op_t base_alu_op(input logic [2:0] f3, input logic alt);
        alu_op_t op;
        case (f3)
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational RV32I decode of the ID-stage instruction into a control bundle.
// CTRL_MEXT_EN enables MUL/MULH/MULHSU/MULHU; otherwise funct7=0000001 OP is illegal.
module ctrl_decoder
    import ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output imm_fmt_t    imm_src,
    output logic        illegal
);

    opcode_t    opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       unused_fields;

    assign opc           = opcode_t'(instr[6:0]);
    assign f3            = instr[14:12];
    assign f7            = instr[31:25];
    assign unused_fields = ^instr[24:7];

    always_comb begin
        ctrl        = BUBBLE;
        imm_src     = IMM_I;
        illegal     = 1'b0;
        ctrl.funct3 = f3;
        case (opc)
            OPC_LUI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src_b = 1'b1;
                ctrl.alu_ctrl  = ALU_PASS_B;
                imm_src        = IMM_U;
            end
            OPC_AUIPC: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 1'b1;
                imm_src        = IMM_U;
            end
            OPC_JAL: begin
                ctrl.reg_write  = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = 1'b1;
                ctrl.result_src = RES_PC4;
                imm_src         = IMM_J;
            end
            OPC_JALR: begin
                ctrl.reg_write     = 1'b1;
                ctrl.jump          = 1'b1;
                ctrl.alu_src_b     = 1'b1;
                ctrl.pc_target_sel = 1'b1;
                ctrl.result_src    = RES_PC4;
                illegal            = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                ctrl.branch   = 1'b1;
                ctrl.alu_ctrl = ALU_SUB;
                imm_src       = IMM_B;
                illegal       = (f3[2:1] == 2'b01);
            end
            OPC_LOAD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src_b  = 1'b1;
                ctrl.result_src = RES_MEM;
                illegal         = (f3 == 3'b011) || (f3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src_b = 1'b1;
                imm_src        = IMM_S;
                illegal        = (f3 > 3'b010);
            end
            OPC_OP_IMM: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src_b = 1'b1;
                ctrl.alu_ctrl  = base_alu_op(f3, f7[5]);
                if (f3 == 3'b001)
                    illegal = (f7 != F7_BASE);
                else if (f3 == 3'b101)
                    illegal = (f7 != F7_BASE) && (f7 != F7_ALT);
            end
            OPC_OP: begin
                ctrl.reg_write = 1'b1;
                if (f7 == F7_BASE) begin
                    ctrl.alu_ctrl = base_alu_op(f3, 1'b0);
                end else if (f7 == F7_ALT) begin
                    case (f3)
                        3'b000:  ctrl.alu_ctrl = ALU_SUB;
                        3'b101:  ctrl.alu_ctrl = ALU_SRA;
                        default: illegal = 1'b1;
                    endcase
`ifdef CTRL_MEXT_EN
                end else if (f7 == F7_MEXT) begin
                    case (f3)
                        3'b000:  ctrl.alu_ctrl = ALU_MUL;
                        3'b001:  ctrl.alu_ctrl = ALU_MULH;
                        3'b010:  ctrl.alu_ctrl = ALU_MULHSU;
                        3'b011:  ctrl.alu_ctrl = ALU_MULHU;
                        default: illegal = 1'b1;
                    endcase
`endif
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            ctrl    = BUBBLE;
            imm_src = IMM_I;
        end
    end

endmodule

// File: rtl/pipelined_control_unit.sv
// RV32I control unit: D-stage decode plus ID/EX, EX/MEM, MEM/WB control registers
// and EX-stage redirect resolution. CTRL_MEXT_EN adds the M-extension multiplies.
module pipelined_control_unit
    import ctrl_pkg::*;
#(
    parameter int unsigned ALU_CTRL_W   = 4,
    parameter int unsigned RESULT_SRC_W = 2,
    parameter int unsigned IMM_SRC_W    = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [31:0]             instr_d,
    input  logic                    stall_e,
    input  logic                    flush_e,
    input  logic                    zero_e,
    input  logic                    lt_e,
    input  logic                    ltu_e,
    output logic [IMM_SRC_W-1:0]    imm_src_d,
    output logic                    illegal_d,
    output logic [ALU_CTRL_W-1:0]   alu_ctrl_e,
    output logic                    alu_src_a_e,
    output logic                    alu_src_b_e,
    output logic                    pc_src_e,
    output logic                    pc_target_sel_e,
    output logic [RESULT_SRC_W-1:0] result_src_e,
    output logic                    reg_write_e,
    output logic                    mem_write_m,
    output logic [2:0]              funct3_m,
    output logic                    reg_write_m,
    output logic [RESULT_SRC_W-1:0] result_src_m,
    output logic                    reg_write_w,
    output logic [RESULT_SRC_W-1:0] result_src_w
);

    ctrl_t       ctrl_d;
    ctrl_t       ctrl_e;
    imm_fmt_t    imm_fmt_d;
    result_sel_t res_m;
    result_sel_t res_w;
    logic        cond_e;

    ctrl_decoder u_decoder (
        .instr   (instr_d),
        .ctrl    (ctrl_d),
        .imm_src (imm_fmt_d),
        .illegal (illegal_d)
    );

    assign imm_src_d = IMM_SRC_W'(imm_fmt_d);

    // Flush outranks stall so a squashed instruction never survives a hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_e <= BUBBLE;
        end else if (flush_e) begin
            ctrl_e <= BUBBLE;
        end else if (!stall_e) begin
            ctrl_e <= ctrl_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_m <= 1'b0;
            mem_write_m <= 1'b0;
            funct3_m    <= '0;
            res_m       <= RES_ALU;
            reg_write_w <= 1'b0;
            res_w       <= RES_ALU;
        end else begin
            reg_write_m <= ctrl_e.reg_write;
            mem_write_m <= ctrl_e.mem_write;
            funct3_m    <= ctrl_e.funct3;
            res_m       <= ctrl_e.result_src;
            reg_write_w <= reg_write_m;
            res_w       <= res_m;
        end
    end

    always_comb begin
        cond_e = 1'b0;
        case (ctrl_e.funct3)
            3'b000:  cond_e = zero_e;
            3'b001:  cond_e = !zero_e;
            3'b100:  cond_e = lt_e;
            3'b101:  cond_e = !lt_e;
            3'b110:  cond_e = ltu_e;
            3'b111:  cond_e = !ltu_e;
            default: cond_e = 1'b0;
        endcase
        pc_src_e = ctrl_e.jump | (ctrl_e.branch & cond_e);
    end

    assign alu_ctrl_e      = ALU_CTRL_W'(ctrl_e.alu_ctrl);
    assign alu_src_a_e     = ctrl_e.alu_src_a;
    assign alu_src_b_e     = ctrl_e.alu_src_b;
    assign pc_target_sel_e = ctrl_e.pc_target_sel;
    assign result_src_e    = RESULT_SRC_W'(ctrl_e.result_src);
    assign reg_write_e     = ctrl_e.reg_write;
    assign result_src_m    = RESULT_SRC_W'(res_m);
    assign result_src_w    = RESULT_SRC_W'(res_w);

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Scoreboard bench for pipelined_control_unit: a mask/match instruction table
// models decode, and the pipeline is tracked as which instruction sits in E/M/W.
module tb_pipelined_control_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr_d = 32'h003100B3;
    logic        stall_e = 1'b0, flush_e = 1'b0;
    logic        zero_e = 1'b0, lt_e = 1'b0, ltu_e = 1'b0;

    logic [2:0] imm_src_d;
    logic       illegal_d;
    logic [3:0] alu_ctrl_e;
    logic       alu_src_a_e, alu_src_b_e, pc_src_e, pc_target_sel_e, reg_write_e;
    logic [1:0] result_src_e, result_src_m, result_src_w;
    logic       mem_write_m, reg_write_m, reg_write_w;
    logic [2:0] funct3_m;

    pipelined_control_unit #(
        .ALU_CTRL_W   (4),
        .RESULT_SRC_W (2),
        .IMM_SRC_W    (3)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .instr_d         (instr_d),
        .stall_e         (stall_e),
        .flush_e         (flush_e),
        .zero_e          (zero_e),
        .lt_e            (lt_e),
        .ltu_e           (ltu_e),
        .imm_src_d       (imm_src_d),
        .illegal_d       (illegal_d),
        .alu_ctrl_e      (alu_ctrl_e),
        .alu_src_a_e     (alu_src_a_e),
        .alu_src_b_e     (alu_src_b_e),
        .pc_src_e        (pc_src_e),
        .pc_target_sel_e (pc_target_sel_e),
        .result_src_e    (result_src_e),
        .reg_write_e     (reg_write_e),
        .mem_write_m     (mem_write_m),
        .funct3_m        (funct3_m),
        .reg_write_m     (reg_write_m),
        .result_src_m    (result_src_m),
        .reg_write_w     (reg_write_w),
        .result_src_w    (result_src_w)
    );

    always #5 clk = ~clk;

    typedef enum int { C_R, C_IALU, C_LOAD, C_STORE, C_BR, C_JAL, C_JALR, C_LUI, C_AUIPC } cls_t;
    typedef struct { logic [31:0] mask; logic [31:0] match; cls_t cls; int alu; int cond; } ent_t;
    typedef struct { bit ill; int imm; bit rw; bit mw; bit br; bit jmp; bit sa; bit sb; bit tsel;
                     int rsrc; int alu; int f3; int cond; } att_t;
    typedef struct { int imm_d; bit ill_d; int alu_e; bit sa_e; bit sb_e; bit pcs_e; bit tsel_e;
                     int rsrc_e; bit rw_e; bit mw_m; int f3_m; bit rw_m; int rsrc_m; bit rw_w;
                     int rsrc_w; } snap_t;

    ent_t  tbl[$];
    snap_t sbq[$];
    int    errors = 0;
    int    checks = 0;

    logic [31:0] occ_e, occ_m, occ_w;
    bit          v_e = 0, v_m = 0, v_w = 0;

    localparam logic [31:0] ADD  = 32'h003100B3;
    localparam logic [31:0] M_R  = 32'hFE00707F;
    localparam logic [31:0] M_F3 = 32'h0000707F;
    localparam logic [31:0] M_OP = 32'h0000007F;

    task automatic add(input logic [31:0] m, input logic [31:0] t, input cls_t c, input int alu, input int cond);
        tbl.push_back('{m, t, c, alu, cond});
    endtask

    task automatic build_table();
        add(M_R, 32'h00000033, C_R, 0, 0);    add(M_R, 32'h40000033, C_R, 1, 0);
        add(M_R, 32'h00001033, C_R, 7, 0);    add(M_R, 32'h00002033, C_R, 5, 0);
        add(M_R, 32'h00003033, C_R, 6, 0);    add(M_R, 32'h00004033, C_R, 4, 0);
        add(M_R, 32'h00005033, C_R, 8, 0);    add(M_R, 32'h40005033, C_R, 9, 0);
        add(M_R, 32'h00006033, C_R, 3, 0);    add(M_R, 32'h00007033, C_R, 2, 0);
`ifdef CTRL_MEXT_EN
        add(M_R, 32'h02000033, C_R, 11, 0);   add(M_R, 32'h02001033, C_R, 12, 0);
        add(M_R, 32'h02002033, C_R, 13, 0);   add(M_R, 32'h02003033, C_R, 14, 0);
`endif
        add(M_F3, 32'h00000013, C_IALU, 0, 0); add(M_F3, 32'h00002013, C_IALU, 5, 0);
        add(M_F3, 32'h00003013, C_IALU, 6, 0); add(M_F3, 32'h00004013, C_IALU, 4, 0);
        add(M_F3, 32'h00006013, C_IALU, 3, 0); add(M_F3, 32'h00007013, C_IALU, 2, 0);
        add(M_R, 32'h00001013, C_IALU, 7, 0);  add(M_R, 32'h00005013, C_IALU, 8, 0);
        add(M_R, 32'h40005013, C_IALU, 9, 0);
        add(M_F3, 32'h00000003, C_LOAD, 0, 0); add(M_F3, 32'h00001003, C_LOAD, 0, 0);
        add(M_F3, 32'h00002003, C_LOAD, 0, 0); add(M_F3, 32'h00004003, C_LOAD, 0, 0);
        add(M_F3, 32'h00005003, C_LOAD, 0, 0);
        add(M_F3, 32'h00000023, C_STORE, 0, 0); add(M_F3, 32'h00001023, C_STORE, 0, 0);
        add(M_F3, 32'h00002023, C_STORE, 0, 0);
        add(M_F3, 32'h00000063, C_BR, 1, 0);   add(M_F3, 32'h00001063, C_BR, 1, 1);
        add(M_F3, 32'h00004063, C_BR, 1, 2);   add(M_F3, 32'h00005063, C_BR, 1, 3);
        add(M_F3, 32'h00006063, C_BR, 1, 4);   add(M_F3, 32'h00007063, C_BR, 1, 5);
        add(M_OP, 32'h0000006F, C_JAL, 0, 0);  add(M_F3, 32'h00000067, C_JALR, 0, 0);
        add(M_OP, 32'h00000037, C_LUI, 10, 0); add(M_OP, 32'h00000017, C_AUIPC, 0, 0);
    endtask

    function automatic att_t attr(input bit v, input logic [31:0] ins);
        att_t a;
        a = '{default: 0};
        if (!v) return a;
        a.ill = 1'b1;
        for (int i = 0; i < tbl.size(); i++) begin
            if ((ins & tbl[i].mask) == tbl[i].match) begin
                a.ill  = 1'b0;
                a.alu  = tbl[i].alu;
                a.cond = tbl[i].cond;
                a.f3   = int'(ins[14:12]);
                case (tbl[i].cls)
                    C_R:     a.rw = 1;
                    C_IALU:  begin a.rw = 1; a.sb = 1; end
                    C_LOAD:  begin a.rw = 1; a.sb = 1; a.rsrc = 1; end
                    C_STORE: begin a.mw = 1; a.sb = 1; a.imm = 1; end
                    C_BR:    begin a.br = 1; a.imm = 2; end
                    C_JAL:   begin a.rw = 1; a.jmp = 1; a.sa = 1; a.sb = 1; a.rsrc = 2; a.imm = 3; end
                    C_JALR:  begin a.rw = 1; a.jmp = 1; a.sb = 1; a.tsel = 1; a.rsrc = 2; end
                    C_LUI:   begin a.rw = 1; a.sb = 1; a.imm = 4; end
                    C_AUIPC: begin a.rw = 1; a.sa = 1; a.sb = 1; a.imm = 4; end
                    default: ;
                endcase
                break;
            end
        end
        return a;
    endfunction

    function automatic bit taken(input int cond, input bit z, input bit l, input bit lu);
        case (cond)
            0: return z;
            1: return !z;
            2: return l;
            3: return !l;
            4: return lu;
            default: return !lu;
        endcase
    endfunction

    // One cycle: model the edge just taken, then drive new inputs and push expectations.
    task automatic step(input logic [31:0] ins, input bit st, input bit fl,
                        input bit z, input bit l, input bit lu, input bit rs);
        att_t ad, ae, am, aw;
        snap_t s;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            v_e = 0; v_m = 0; v_w = 0;
        end else begin
            v_w = v_m; occ_w = occ_m;
            v_m = v_e; occ_m = occ_e;
            if (flush_e) v_e = 0;
            else if (!stall_e) begin v_e = 1; occ_e = instr_d; end
        end
        instr_d = ins; stall_e = st; flush_e = fl;
        zero_e = z; lt_e = l; ltu_e = lu; rst_n = rs;
        if (!rs) begin v_e = 0; v_m = 0; v_w = 0; end
        ad = attr(1, ins);
        ae = attr(v_e, occ_e);
        am = attr(v_m, occ_m);
        aw = attr(v_w, occ_w);
        s.imm_d  = ad.imm;   s.ill_d  = ad.ill;
        s.alu_e  = ae.alu;   s.sa_e   = ae.sa;   s.sb_e = ae.sb;
        s.pcs_e  = ae.jmp | (ae.br & taken(ae.cond, z, l, lu));
        s.tsel_e = ae.tsel;  s.rsrc_e = ae.rsrc; s.rw_e = ae.rw;
        s.mw_m   = am.mw;    s.f3_m   = am.f3;   s.rw_m = am.rw; s.rsrc_m = am.rsrc;
        s.rw_w   = aw.rw;    s.rsrc_w = aw.rsrc;
        sbq.push_back(s);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h (instr_d=%h)", nm, $time, act, exp, instr_d);
        end
    endtask

    initial begin : monitor
        snap_t s;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                s = sbq.pop_front();
                chk("imm_src_d",       32'(imm_src_d),       32'(s.imm_d));
                chk("illegal_d",       32'(illegal_d),       32'(s.ill_d));
                chk("alu_ctrl_e",      32'(alu_ctrl_e),      32'(s.alu_e));
                chk("alu_src_a_e",     32'(alu_src_a_e),     32'(s.sa_e));
                chk("alu_src_b_e",     32'(alu_src_b_e),     32'(s.sb_e));
                chk("pc_src_e",        32'(pc_src_e),        32'(s.pcs_e));
                chk("pc_target_sel_e", 32'(pc_target_sel_e), 32'(s.tsel_e));
                chk("result_src_e",    32'(result_src_e),    32'(s.rsrc_e));
                chk("reg_write_e",     32'(reg_write_e),     32'(s.rw_e));
                chk("mem_write_m",     32'(mem_write_m),     32'(s.mw_m));
                chk("funct3_m",        32'(funct3_m),        32'(s.f3_m));
                chk("reg_write_m",     32'(reg_write_m),     32'(s.rw_m));
                chk("result_src_m",    32'(result_src_m),    32'(s.rsrc_m));
                chk("reg_write_w",     32'(reg_write_w),     32'(s.rw_w));
                chk("result_src_w",    32'(result_src_w),    32'(s.rsrc_w));
            end
        end
    end

    initial begin : driver
        logic [31:0] ins;
        int          k;
        build_table();
        repeat (3) step(ADD, 0, 0, 0, 0, 0, 0);
        step(ADD, 0, 0, 0, 0, 0, 1);
        step(ADD, 0, 0, 0, 0, 0, 1);
        step(32'h402081B3, 0, 0, 0, 0, 0, 1);
        step(32'h00500093, 0, 0, 0, 0, 0, 1);
        step(32'h4010D093, 0, 0, 0, 0, 0, 1);
        step(32'h0020C463, 0, 0, 0, 0, 0, 1);
        step(32'h0020C463, 0, 0, 0, 1, 0, 1);
        step(32'h0020F463, 0, 0, 0, 0, 0, 1);
        step(ADD,          0, 0, 0, 0, 0, 1);
        step(32'h0000A103, 0, 0, 0, 0, 0, 1);
        repeat (3) step(ADD, 0, 0, 0, 0, 0, 1);
        step(32'h008000EF, 0, 0, 0, 0, 0, 1);
        step(ADD,          1, 1, 0, 0, 0, 1);
        step(ADD,          0, 0, 0, 0, 0, 1);
        step(32'h402081B3, 0, 0, 0, 0, 0, 1);
        step(ADD,          1, 0, 0, 0, 0, 1);
        step(ADD,          1, 0, 0, 0, 0, 1);
        step(ADD,          0, 0, 0, 0, 0, 1);
        step(32'h02208033, 0, 0, 0, 0, 0, 1);
        step(ADD,          0, 0, 0, 0, 0, 1);
        step(32'h0000A103, 0, 0, 0, 0, 0, 1);
        step(ADD,          0, 0, 0, 0, 0, 1);
        step(ADD,          0, 0, 0, 0, 0, 0);
        step(ADD,          0, 0, 0, 0, 0, 1);
        step(ADD,          0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(7) == 0) begin
                ins = $urandom();
            end else begin
                k   = int'($urandom_range(tbl.size() - 1));
                ins = tbl[k].match | ($urandom() & ~tbl[k].mask);
            end
            step(ins, $urandom_range(5) == 0, $urandom_range(7) == 0,
                 1'($urandom()), 1'($urandom()), 1'($urandom()), $urandom_range(63) != 0);
        end
        repeat (4) step(ADD, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
